// File: rtl/sys_pkg.sv
// Shared constants for the syscall path: instruction and syscall codes,
// FSM state encoding, and the read-request decode helper.
package sys_pkg;

    localparam logic [31:0] SYSCALL_ID  = 32'd26;
    localparam logic [31:0] SYS_DISPLAY = 32'd1;
    localparam logic [31:0] SYS_READ    = 32'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic is_read_req(input logic [31:0] id,
                                         input logic [31:0] code,
                                         input logic [31:0] read_code);
        return (id == SYSCALL_ID) && (code == read_code);
    endfunction

endpackage

// File: rtl/sys_fifo.sv
// Synchronous FIFO holding console input words. Head is presented
// combinationally on dout. Push when full and pop when empty are ignored.
module sys_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == DEPTH_CNT);
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/syscall_input.sv
// Console-input responder for the read syscall. Words arrive from a
// producer through a valid/ready FIFO; a read syscall pops one word onto rd
// with a one-cycle rd_valid strobe, stalling the processor while the FIFO
// is empty.
//
// Build option: define SYSCALL_INPUT_ECHO_EN to print every delivered word
// (decimal) in simulation while rd_valid is high. Timing is unaffected.
//
// state   | meaning
// IDLE    | no outstanding read, rd_valid low
// WAIT    | read seen on empty FIFO, stall high until a word arrives
// RESP    | word just delivered, rd_valid high for this cycle
module syscall_input
    import sys_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 8,
    parameter logic [31:0] READ_CODE = SYS_READ
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [31:0]            instr_ID,
    input  logic [31:0]            rs,
    output logic [WIDTH-1:0]       rd,
    output logic                   rd_valid,
    output logic                   stall,
    output logic [$clog2(DEPTH):0] count
);

    logic [1:0]       state;
    logic             req;
    logic             take;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;

    assign req      = is_read_req(instr_ID, rs, READ_CODE);
    assign in_ready = !full;

    // Pop the head whenever the FSM is about to deliver it. The FIFO count
    // seen here is pre-edge, so a same-edge push cannot satisfy a read.
    always_comb begin
        take = 1'b0;
        case (state)
            ST_WAIT: take = !empty;
            default: take = req && !empty;
        endcase
    end

    sys_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (take),
        .din   (in_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Read FSM and registered outputs; RESP behaves like IDLE so that
    // back-to-back reads give back-to-back strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rd       <= '0;
            rd_valid <= 1'b0;
            stall    <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (!empty) begin
                        rd       <= head;
                        rd_valid <= 1'b1;
                        stall    <= 1'b0;
                        state    <= ST_RESP;
                    end
                end
                default: begin
                    if (req) begin
                        if (!empty) begin
                            rd       <= head;
                            rd_valid <= 1'b1;
                            state    <= ST_RESP;
                        end else begin
                            rd_valid <= 1'b0;
                            stall    <= 1'b1;
                            state    <= ST_WAIT;
                        end
                    end else begin
                        rd_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SYSCALL_INPUT_ECHO_EN
    // Echo each delivered word to the simulation console.
    always @(posedge clk) begin
        if (reset && rd_valid) begin
            $display("%0d", rd);
        end
    end
`else
`endif

endmodule

// File: tb/tb_syscall_input.sv
module tb_syscall_input;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic [31:0] instr_ID = '0;
    logic [31:0] rs = '0;
    logic [31:0] rd;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  count;

    int tests = 0;
    int fails = 0;
    bit run_cmp = 0;

    syscall_input #(.WIDTH(32), .DEPTH(DEPTH), .READ_CODE(32'd5)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .instr_ID (instr_ID),
        .rs       (rs),
        .rd       (rd),
        .rd_valid (rd_valid),
        .stall    (stall),
        .count    (count)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: a queue of words plus one "read outstanding" flag.
    logic [31:0] mq[$];
    bit          m_wait;
    logic [31:0] m_rd;
    bit          m_valid;
    bit          m_acc;
    bit          m_req;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_wait  = 0;
            m_rd    = '0;
            m_valid = 0;
        end else begin
            m_acc   = in_valid && (mq.size() < DEPTH);
            m_req   = (instr_ID == 32'd26) && (rs == 32'd5);
            m_valid = 0;
            if (m_wait || m_req) begin
                if (mq.size() > 0) begin
                    m_rd    = mq.pop_front();
                    m_valid = 1;
                    m_wait  = 0;
                end else begin
                    m_wait = 1;
                end
            end
            if (m_acc) mq.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("rd", rd, m_rd);
            check("rd_valid", 32'(rd_valid), 32'(m_valid));
            check("stall", 32'(stall), 32'(m_wait));
            check("count", 32'(count), 32'(mq.size()));
            check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            check("valid_stall_excl", 32'(rd_valid && stall), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_req(input bit on);
        instr_ID = on ? 32'd26 : 32'd0;
        rs       = on ? 32'd5 : 32'd0;
    endtask

    int sc;
    int n;
    bit acc;

    initial begin
        tick();
        tick();
        reset = 1'b1;
        run_cmp = 1;
        tick();
        check("rst_rd", rd, 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Three pushes then three back-to-back reads.
        in_valid = 1'b1;
        in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        in_data = 32'h33; tick();
        in_valid = 1'b0;
        check("b2b_count_pre", 32'(count), 32'd3);
        read_req(1);
        tick(); check("b2b_rd0", rd, 32'h11); check("b2b_v0", 32'(rd_valid), 32'd1);
        tick(); check("b2b_rd1", rd, 32'h22); check("b2b_v1", 32'(rd_valid), 32'd1);
        tick(); check("b2b_rd2", rd, 32'h33); check("b2b_v2", 32'(rd_valid), 32'd1);
        read_req(0);
        tick();
        check("b2b_v_end", 32'(rd_valid), 32'd0);
        check("b2b_count_end", 32'(count), 32'd0);

        // Read on empty FIFO, word arrives later.
        sc = 0;
        read_req(1);
        tick();
        read_req(0);
        if (stall) sc++;
        tick(); if (stall) sc++;
        tick(); if (stall) sc++;
        in_valid = 1'b1; in_data = 32'hABCD;
        tick(); if (stall) sc++;
        in_valid = 1'b0;
        tick();
        check("wait_stall_cycles", 32'(sc), 32'd4);
        check("wait_rd", rd, 32'hABCD);
        check("wait_valid", 32'(rd_valid), 32'd1);
        check("wait_stall_low", 32'(stall), 32'd0);
        tick();

        // Fill to full with a held producer, pop one, ninth word enters.
        n = 0;
        in_valid = 1'b1;
        in_data = 32'h100;
        for (int i = 0; i < 10; i++) begin
            read_req(i == 8);
            acc = in_ready;
            tick();
            if (acc) n++;
            in_data = 32'h100 + 32'(n);
            if (i == 7) check("full_in_ready", 32'(in_ready), 32'd0);
            if (i == 8) check("full_pop_rd", rd, 32'h100);
        end
        in_valid = 1'b0;
        read_req(0);
        check("full_accepted", 32'(n), 32'd9);
        check("full_count", 32'(count), 32'd8);
        read_req(1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) check("drain_first", rd, 32'h101);
            if (i == 7) check("drain_last", rd, 32'h108);
        end
        read_req(0);
        tick();

        // Read and push on the same edge to an empty FIFO.
        read_req(1);
        in_valid = 1'b1; in_data = 32'h55;
        tick();
        read_req(0);
        in_valid = 1'b0;
        check("same_stall", 32'(stall), 32'd1);
        check("same_valid", 32'(rd_valid), 32'd0);
        check("same_count", 32'(count), 32'd1);
        tick();
        check("same_rd", rd, 32'h55);
        check("same_valid2", 32'(rd_valid), 32'd1);
        check("same_stall2", 32'(stall), 32'd0);
        tick();

        // Non-read syscalls are ignored.
        in_valid = 1'b1; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        instr_ID = 32'd26; rs = 32'd1;  tick();
        instr_ID = 32'd26; rs = 32'd10; tick();
        instr_ID = 32'd25; rs = 32'd5;  tick();
        check("ign_valid", 32'(rd_valid), 32'd0);
        check("ign_count", 32'(count), 32'd1);
        check("ign_rd", rd, 32'h55);
        read_req(1);
        tick();
        read_req(0);
        check("ign_then_read", rd, 32'h77);
        tick();

        // Reset mid-RESP with a queued word.
        in_valid = 1'b1;
        in_data = 32'h61; tick();
        in_data = 32'h62; tick();
        in_valid = 1'b0;
        read_req(1);
        tick();
        read_req(0);
        check("mid_resp_rd", rd, 32'h61);
        #2 reset = 1'b0;
        #1;
        check("rst_resp_count", 32'(count), 32'd0);
        check("rst_resp_rd", rd, 32'd0);
        check("rst_resp_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Reset mid-WAIT drops stall immediately.
        read_req(1);
        tick();
        read_req(0);
        check("mid_wait_stall", 32'(stall), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_wait_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_count", 32'(count), 32'd0);
        tick();

        run_cmp = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
